uart_tx_frame: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8N1 sender. It is configurable at elaboration for data width, parity mode and stop-bit count. It uses a valid/ready input handshake with a one-entry holding register, so consecutive frames go out back-to-back with no idle gap. It sits between any byte/word producer (e.g. a message ROM sequencer or FIFO) and the board's serial TX pin.

---
 rtl/uart_tx_frame.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_frame
// Purpose  : Parametrised UART transmitter with a one-entry holding register,
//            configurable data width, parity and stop bits.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_frame #(
    parameter int freq_hz   = 100_000_000,
    parameter int baudrate  = 115_200,
    parameter int data_bits = 8,
    parameter int parity    = 0,
    parameter int stop_bits = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [data_bits-1:0] idata,
    input  logic                 ivalid,
    output logic                 iready,
    output logic                 busy,
    output logic                 tx
);

    localparam int c_tpb = (freq_hz + baudrate / 2) / baudrate;
    localparam int c_cw  = $clog2(c_tpb) + 1;

    localparam logic [c_cw-1:0] c_tpb_last  = c_cw'(c_tpb - 1);
    localparam logic [3:0]      c_data_last = 4'(data_bits - 1);
    localparam logic [3:0]      c_stop_last = 4'(stop_bits - 1);
    localparam bit              c_has_par   = (parity != 0);
    localparam bit              c_odd_par   = (parity == 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    if (c_tpb < 2) begin : g_chk_tpb
        $error("uart_tx_frame: bit period below 2 clocks");
    end
    if (data_bits < 5 || data_bits > 9) begin : g_chk_data_bits
        $error("uart_tx_frame: data_bits must be 5..9");
    end
    if (parity < 0 || parity > 2) begin : g_chk_parity
        $error("uart_tx_frame: parity must be 0, 1 or 2");
    end
    if (stop_bits != 1 && stop_bits != 2) begin : g_chk_stop_bits
        $error("uart_tx_frame: stop_bits must be 1 or 2");
    end

    logic [2:0]           r_state;
    logic [c_cw-1:0]      r_baud_cnt;
    logic [3:0]           r_bit_cnt;
    logic [data_bits-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_hold_full;
    logic [data_bits-1:0] r_hold_data;

    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic                 w_start;
    logic [data_bits-1:0] w_src;
    logic                 w_src_par;

    assign w_accept    = ivalid && !r_hold_full;
    assign w_bit_end   = (r_baud_cnt == c_tpb_last);
    assign w_frame_end = (r_state == c_st_stop) && w_bit_end && (r_bit_cnt == c_stop_last);
    // An empty holding register lets an accepted word go straight to the shifter.
    assign w_start     = ((r_state == c_st_idle) || w_frame_end) && (r_hold_full || w_accept);
    assign w_src       = r_hold_full ? r_hold_data : idata;
    assign w_src_par   = c_odd_par ? ~(^w_src) : (^w_src);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else if (w_start && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (w_accept && !w_start) begin
            r_hold_full <= 1'b1;
            r_hold_data <= idata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else if (w_start) begin
            r_state    <= c_st_start;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= w_src;
            r_par      <= w_src_par;
            r_tx       <= 1'b0;
        end else if (r_state == c_st_idle) begin
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
            if (w_bit_end) begin
                case (r_state)
                    c_st_start: begin
                        r_state   <= c_st_data;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end
                    c_st_data: begin
                        if (r_bit_cnt == c_data_last) begin
                            r_bit_cnt <= '0;
                            if (c_has_par) begin
                                r_state <= c_st_parity;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= c_st_stop;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end
                    c_st_parity: begin
                        r_state   <= c_st_stop;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                    end
                    c_st_stop: begin
                        // Last stop period with nothing queued; w_start covers the queued case.
                        if (r_bit_cnt == c_stop_last) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                        r_tx <= 1'b1;
                    end
                    default: begin
                        r_state <= c_st_idle;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign iready = !r_hold_full;
    assign busy   = (r_state != c_st_idle) || r_hold_full;
    assign tx     = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_frame
// Purpose  : Self-checking bench for uart_tx_frame; four configurations share
//            one line-level reference model built from the frame rules.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_frame;

    localparam int c_tpb = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] drv_data  = '0;
    logic       drv_valid = 1'b0;
    logic [1:0] sel = 2'd0;

    logic [3:0] tx_v, busy_v, iready_v;
    logic       tx_m, busy_m, iready_m;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int cycle = 0;
    bit last_acc = 1'b0;

    int cfg_db  [4] = '{8, 8, 8, 7};
    int cfg_par [4] = '{0, 2, 1, 0};
    int cfg_sb  [4] = '{1, 1, 1, 2};

    logic line_q[$];

    always #5 clk = ~clk;

    uart_tx_frame #(.freq_hz(1_000_000), .baudrate(250_000), .data_bits(8), .parity(0), .stop_bits(1)) u_8n1 (
        .clk(clk), .rst(rst), .idata(drv_data), .ivalid(drv_valid && sel == 2'd0),
        .iready(iready_v[0]), .busy(busy_v[0]), .tx(tx_v[0]));
    uart_tx_frame #(.freq_hz(1_000_000), .baudrate(250_000), .data_bits(8), .parity(2), .stop_bits(1)) u_8e1 (
        .clk(clk), .rst(rst), .idata(drv_data), .ivalid(drv_valid && sel == 2'd1),
        .iready(iready_v[1]), .busy(busy_v[1]), .tx(tx_v[1]));
    uart_tx_frame #(.freq_hz(1_000_000), .baudrate(250_000), .data_bits(8), .parity(1), .stop_bits(1)) u_8o1 (
        .clk(clk), .rst(rst), .idata(drv_data), .ivalid(drv_valid && sel == 2'd2),
        .iready(iready_v[2]), .busy(busy_v[2]), .tx(tx_v[2]));
    uart_tx_frame #(.freq_hz(1_000_000), .baudrate(250_000), .data_bits(7), .parity(0), .stop_bits(2)) u_7n2 (
        .clk(clk), .rst(rst), .idata(drv_data[6:0]), .ivalid(drv_valid && sel == 2'd3),
        .iready(iready_v[3]), .busy(busy_v[3]), .tx(tx_v[3]));

    always_comb begin
        tx_m     = tx_v[sel];
        busy_m   = busy_v[sel];
        iready_m = iready_v[sel];
    end

    function automatic int frame_len(input int s);
        return c_tpb * (1 + cfg_db[s] + (cfg_par[s] != 0 ? 1 : 0) + cfg_sb[s]);
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cfg=%0d cycle=%0d observed=%b expected=%b", tag, sel, cycle, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s cfg=%0d observed=%0d expected=%0d", tag, sel, obs, exp);
        end
    endtask

    // Appends one whole frame, TPB samples per bit, to the expected line.
    task automatic push_frame(input logic [7:0] w);
        int   ones = 0;
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < cfg_db[sel]; i++) begin
            bits.push_back(w[i]);
            ones += int'(w[i]);
        end
        if (cfg_par[sel] == 2) bits.push_back((ones % 2) == 1);
        if (cfg_par[sel] == 1) bits.push_back((ones % 2) == 0);
        for (int i = 0; i < cfg_sb[sel]; i++) bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < c_tpb; k++) line_q.push_back(bits[i]);
    endtask

    // Checks the current cycle, applies the handshake at the next edge, advances.
    task automatic tick();
        int   sz;
        logic exp_tx;
        sz     = line_q.size();
        exp_tx = (sz > 0) ? line_q.pop_front() : 1'b1;
        chk("tx", tx_m, exp_tx);
        chk("busy", busy_m, sz > 0);
        chk("iready", iready_m, sz <= frame_len(sel));
        last_acc = drv_valid && !rst && (sz <= frame_len(sel));
        if (last_acc) begin
            n_acc++;
            push_frame(drv_data);
        end
        if (rst) line_q.delete();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic send_one(input logic [1:0] s, input logic [7:0] w, input int tail);
        sel       = s;
        drv_data  = w;
        drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        drv_data  = 8'($urandom);
        repeat (tail) tick();
    endtask

    task automatic random_run(input logic [1:0] s, input int n);
        int start = n_acc;
        int guard = 0;
        sel = s;
        while ((n_acc - start) < n && guard < 20000) begin
            if (drv_valid && !last_acc) begin
                drv_data = 8'($urandom);
            end else begin
                drv_valid = ($urandom_range(0, 2) != 0);
                drv_data  = 8'($urandom);
            end
            tick();
            guard++;
        end
        drv_valid = 1'b0;
        guard = 0;
        while (line_q.size() > 0 && guard < 2000) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        chk_int("accepted_words", n_acc - start, n);
        chk_int("line_drained", line_q.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // 8N1 0x55, then even and odd parity on 0x07, then 7N2 with bit 7 set on the bus
        send_one(2'd0, 8'h55, 45);
        send_one(2'd1, 8'h07, 48);
        send_one(2'd2, 8'h07, 48);
        send_one(2'd3, 8'hC1, 44);

        // back-to-back pair with ivalid held
        sel       = 2'd0;
        drv_data  = 8'hA5;
        drv_valid = 1'b1;
        tick();
        drv_data  = 8'h3C;
        tick();
        drv_valid = 1'b0;
        repeat (84) tick();

        // reset during a 0xFF frame, then a clean frame
        sel       = 2'd0;
        drv_data  = 8'hFF;
        drv_valid = 1'b1;
        tick();
        drv_valid = 1'b0;
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        send_one(2'd0, 8'h96, 45);

        random_run(2'd0, 100);
        random_run(2'd1, 25);
        random_run(2'd3, 25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
